// File: rtl/ticktocktokens_if.sv
// Host command bus for the ticktocktokens core.
// master: the host that drives commands; slave: the core.
interface ticktocktokens_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/ticktocktokens.sv
// ticktocktokens: bank of NUM_PROC token-counting tick-tock processors.
// Commands arrive on ui_in (addr[2:0], opcode[4:3], subfield[6:5]) with
// the operand on uio_in. TICK updates every processor in parallel from
// pre-tick values and clears the per-tick token window.
// Optional feature macro TTT_PULSE_OUT_EN: when defined, uo_out[i] is a
// one-cycle pulse after the TICK that activated processor i; otherwise
// uo_out[i] is the processor's active level.
// rst_n is an active-high synchronous reset (1 = reset).
module ticktocktokens #(
  parameter int NUM_PROC = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ticktocktokens_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_TOKEN = 2'b10,
    OP_TICK  = 2'b11
  } op_t;

  // Per-processor state and programmed parameters
  logic [CNT_W-1:0]    g   [NUM_PROC];
  logic [CNT_W-1:0]    b   [NUM_PROC];
  logic [CNT_W-1:0]    d   [NUM_PROC];
  logic [CNT_W-1:0]    gt  [NUM_PROC];
  logic [CNT_W-1:0]    bt  [NUM_PROC];
  logic [CNT_W-1:0]    dur [NUM_PROC];
  logic [NUM_PROC-1:0] act;

  logic [NUM_PROC-1:0] veto;
  logic [NUM_PROC-1:0] fire;
  logic [7:0]          out_vec;

  // Command decode
  logic [2:0]       addr;
  op_t              op;
  logic [1:0]       sub;
  logic [CNT_W-1:0] data;
  logic             unused_reserved;

  assign addr            = bus.ui_in[2:0];
  assign op              = op_t'(bus.ui_in[4:3]);
  assign sub             = bus.ui_in[6:5];
  assign data            = bus.uio_in[CNT_W-1:0];
  assign unused_reserved = bus.ui_in[7];

  // Saturating add for token counters
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] c);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, c};
    if (sum[CNT_W]) begin
      return CNT_MAX;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Fire condition per idle processor; DUR=0 fires without activating,
  // so it is folded in here to keep activation and pulse consistent.
  always_comb begin
    veto = '0;
    fire = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      veto[i] = (bt[i] != '0) && (b[i] >= bt[i]);
      fire[i] = !act[i] && (g[i] >= gt[i]) && !veto[i] && (dur[i] != '0);
    end
  end

  // Command execution and tick update of all processors
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_PROC; i++) begin
        g[i]   <= '0;
        b[i]   <= '0;
        d[i]   <= '0;
        gt[i]  <= '0;
        bt[i]  <= '0;
        dur[i] <= '0;
      end
      act <= '0;
    end else if (bus.ena) begin
      case (op)
        OP_LOAD: begin
          for (int i = 0; i < NUM_PROC; i++) begin
            if (addr == 3'(i)) begin
              case (sub)
                2'b00:   gt[i]  <= data;
                2'b01:   bt[i]  <= data;
                2'b10:   dur[i] <= data;
                default: ;
              endcase
            end
          end
        end
        OP_TOKEN: begin
          for (int i = 0; i < NUM_PROC; i++) begin
            if (addr == 3'(i)) begin
              if (sub[0]) begin
                b[i] <= sat_add(b[i], data);
              end else begin
                g[i] <= sat_add(g[i], data);
              end
            end
          end
        end
        OP_TICK: begin
          for (int i = 0; i < NUM_PROC; i++) begin
            g[i] <= '0;
            b[i] <= '0;
            if (act[i]) begin
              // A processor finishing on this tick does not re-evaluate.
              d[i] <= d[i] - CNT_ONE;
              if (d[i] == CNT_ONE) begin
                act[i] <= 1'b0;
              end
            end else if (fire[i]) begin
              act[i] <= 1'b1;
              d[i]   <= dur[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TTT_PULSE_OUT_EN
  logic [NUM_PROC-1:0] pulse;

  // One-cycle activation pulse following the activating TICK
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pulse <= '0;
    end else if (bus.ena && (op == OP_TICK)) begin
      pulse <= fire;
    end else begin
      pulse <= '0;
    end
  end

  // Map pulse bits onto uo_out; unused bits stay 0
  always_comb begin
    out_vec = 8'h00;
    for (int i = 0; i < NUM_PROC; i++) begin
      out_vec[i] = pulse[i];
    end
  end
`else
  // Map active levels onto uo_out; unused bits stay 0
  always_comb begin
    out_vec = 8'h00;
    for (int i = 0; i < NUM_PROC; i++) begin
      out_vec[i] = act[i];
    end
  end
`endif

  assign bus.uo_out  = out_vec;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_ticktocktokens.sv
// Directed self-checking bench for ticktocktokens (level output build).
module tb_ticktocktokens;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ticktocktokens_if bus ();

  ticktocktokens #(.NUM_PROC(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One command cycle; returns 1 time unit after the executing edge.
  task automatic cmd(input logic e, input logic [2:0] a, input logic [1:0] op,
                     input logic [1:0] sub, input logic [7:0] data);
    bus.ena    = e;
    bus.ui_in  = {1'b0, sub, op, a};
    bus.uio_in = data;
    @(posedge clk);
    #1;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
  endtask

  task automatic load(input logic [2:0] a, input logic [1:0] sub, input logic [7:0] v);
    cmd(1'b1, a, 2'b01, sub, v);
  endtask

  task automatic good(input logic [2:0] a, input logic [7:0] n);
    cmd(1'b1, a, 2'b10, 2'b00, n);
  endtask

  task automatic bad(input logic [2:0] a, input logic [7:0] n);
    cmd(1'b1, a, 2'b10, 2'b01, n);
  endtask

  task automatic tick();
    cmd(1'b1, 3'd0, 2'b11, 2'b00, 8'h00);
  endtask

  task automatic test_reset();
    rst_n      = 1'b1;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'hFF;
    bus.uio_in = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL reset_uo_out: got %h want %h", bus.uo_out, 8'h00);
    end
    checks++;
    if (bus.uio_out !== 8'h00) begin
      errors++; $display("FAIL reset_uio_out: got %h want %h", bus.uio_out, 8'h00);
    end
    checks++;
    if (bus.uio_oe !== 8'h00) begin
      errors++; $display("FAIL reset_uio_oe: got %h want %h", bus.uio_oe, 8'h00);
    end
    rst_n      = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL reset_tick: got %h want %h", bus.uo_out, 8'h00);
    end
  endtask

  task automatic test_basic_fire();
    load(3'd3, 2'b00, 8'd5);
    load(3'd3, 2'b10, 8'd2);
    good(3'd3, 8'd5);
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL basic_pre_tick: got %h want %h", bus.uo_out, 8'h00);
    end
    tick();
    checks++;
    if (bus.uo_out !== 8'h08) begin
      errors++; $display("FAIL basic_tick1: got %h want %h", bus.uo_out, 8'h08);
    end
    tick();
    checks++;
    if (bus.uo_out !== 8'h08) begin
      errors++; $display("FAIL basic_tick2: got %h want %h", bus.uo_out, 8'h08);
    end
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL basic_tick3: got %h want %h", bus.uo_out, 8'h00);
    end
  endtask

  task automatic test_window_clear();
    load(3'd0, 2'b00, 8'd5);
    load(3'd0, 2'b10, 8'd1);
    good(3'd0, 8'd4);
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL window_sub_threshold: got %h want %h", bus.uo_out, 8'h00);
    end
    good(3'd0, 8'd1);
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL window_cleared: got %h want %h", bus.uo_out, 8'h00);
    end
  endtask

  task automatic test_veto();
    load(3'd1, 2'b00, 8'd2);
    load(3'd1, 2'b01, 8'd3);
    load(3'd1, 2'b10, 8'd1);
    good(3'd1, 8'd2);
    bad(3'd1, 8'd3);
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL veto_active: got %h want %h", bus.uo_out, 8'h00);
    end
    good(3'd1, 8'd2);
    bad(3'd1, 8'd2);
    tick();
    checks++;
    if (bus.uo_out !== 8'h02) begin
      errors++; $display("FAIL veto_below_bt: got %h want %h", bus.uo_out, 8'h02);
    end
    // Tokens present while active; deactivating tick must not re-fire.
    good(3'd1, 8'd2);
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL veto_no_refire: got %h want %h", bus.uo_out, 8'h00);
    end
    load(3'd1, 2'b01, 8'd0);
    good(3'd1, 8'd2);
    bad(3'd1, 8'd255);
    tick();
    checks++;
    if (bus.uo_out !== 8'h02) begin
      errors++; $display("FAIL veto_bt_zero: got %h want %h", bus.uo_out, 8'h02);
    end
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL veto_dur_one_end: got %h want %h", bus.uo_out, 8'h00);
    end
  endtask

  task automatic test_gt_zero();
    load(3'd4, 2'b10, 8'd1);
    tick();
    checks++;
    if (bus.uo_out !== 8'h10) begin
      errors++; $display("FAIL gt0_tick1: got %h want %h", bus.uo_out, 8'h10);
    end
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL gt0_tick2: got %h want %h", bus.uo_out, 8'h00);
    end
    tick();
    checks++;
    if (bus.uo_out !== 8'h10) begin
      errors++; $display("FAIL gt0_tick3: got %h want %h", bus.uo_out, 8'h10);
    end
    load(3'd4, 2'b10, 8'd0);
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL gt0_dur0: got %h want %h", bus.uo_out, 8'h00);
    end
  endtask

  task automatic test_sat_ena();
    load(3'd5, 2'b00, 8'd255);
    load(3'd5, 2'b10, 8'd1);
    good(3'd5, 8'd200);
    good(3'd5, 8'd200);
    tick();
    checks++;
    if (bus.uo_out !== 8'h20) begin
      errors++; $display("FAIL sat_fire: got %h want %h", bus.uo_out, 8'h20);
    end
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL sat_end: got %h want %h", bus.uo_out, 8'h00);
    end
    // Disabled LOAD of DUR on proc 6 (GT=0) must leave it silent.
    cmd(1'b0, 3'd6, 2'b01, 2'b10, 8'd3);
    // Subfield 11 LOAD is a no-op.
    load(3'd6, 2'b11, 8'd3);
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL ena0_load: got %h want %h", bus.uo_out, 8'h00);
    end
    good(3'd5, 8'd255);
    cmd(1'b0, 3'd0, 2'b11, 2'b00, 8'h00);
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL ena0_tick: got %h want %h", bus.uo_out, 8'h00);
    end
    cmd(1'b0, 3'd5, 2'b10, 2'b00, 8'd1);
    tick();
    checks++;
    if (bus.uo_out !== 8'h20) begin
      errors++; $display("FAIL ena0_kept_tokens: got %h want %h", bus.uo_out, 8'h20);
    end
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL ena_end: got %h want %h", bus.uo_out, 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    load(3'd2, 2'b00, 8'd1);
    load(3'd2, 2'b10, 8'd10);
    good(3'd2, 8'd1);
    tick();
    checks++;
    if (bus.uo_out !== 8'h04) begin
      errors++; $display("FAIL mid_fire: got %h want %h", bus.uo_out, 8'h04);
    end
    tick();
    tick();
    checks++;
    if (bus.uo_out !== 8'h04) begin
      errors++; $display("FAIL mid_active: got %h want %h", bus.uo_out, 8'h04);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got %h want %h", bus.uo_out, 8'h00);
    end
    good(3'd2, 8'd1);
    tick();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++; $display("FAIL mid_params_lost: got %h want %h", bus.uo_out, 8'h00);
    end
    load(3'd2, 2'b00, 8'd1);
    load(3'd2, 2'b10, 8'd10);
    good(3'd2, 8'd1);
    tick();
    checks++;
    if (bus.uo_out !== 8'h04) begin
      errors++; $display("FAIL mid_reprogram: got %h want %h", bus.uo_out, 8'h04);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b1;
    bus.ena    = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    test_reset();
    test_basic_fire();
    test_window_clear();
    test_veto();
    test_gt_zero();
    test_sat_ena();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ticktocktokens.md
Name: ticktocktokens

Overview:
- Tiny Tapeout top-level core: a bank of 8 token-counting "tick-tock" processors.
- Host streams commands on ui_in/uio_in: program thresholds/durations, deliver good/bad tokens, issue global TICK steps.
- Each processor activates for a programmed number of ticks when its good-token count meets threshold without a bad-token veto.
- uo_out exposes per-processor activity.

Parameters:
- NUM_PROC, 8, processor count; must be <= 8 (one uo_out bit each).
- CNT_W, 8, width of counts, thresholds and duration; equals uio_in width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-high reset (1 = reset, sampled on clk).
- ena  input  1  command enable; 0 = commands ignored, state held.
- ui_in  input  8  command: [2:0] processor address, [4:3] opcode, [6:5] subfield, [7] reserved (ignored).
- uio_in  input  8  data operand.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all uio pins inputs).
- uo_out  output  8  bit i = processor i active (registered); bits >= NUM_PROC are 0.

Behaviour:
- Per-processor state: G (good count), B (bad count), D (remaining duration), A (active flag). Params: GT (good threshold), BT (bad threshold), DUR.
- Reset (rst_n=1 at a clk edge): all G, B, D, A, GT, BT, DUR cleared to 0; uo_out = 0 from the next cycle. Applies mid-operation, including loss of programmed params.
- A command executes only on a clk edge with ena=1 and rst_n=0. Effects are visible the cycle after.
- Opcode 00 NOP: no change.
- Opcode 01 LOAD: subfield 00 GT, 01 BT, 10 DUR, 11 no-op; writes uio_in to the selected param of the addressed processor. Addresses >= NUM_PROC are ignored.
- Opcode 10 TOKEN: subfield[5] 0 = good, 1 = bad.
  - Adds uio_in to G or B of the addressed processor, saturating at 2^CNT_W-1.
  - Tokens are accepted while the processor is active.
- Opcode 11 TICK: address/subfield ignored. All processors update in parallel using pre-tick values:
  - If A=1: D <= D-1; if D was 1, A <= 0. A processor deactivating on this tick does not re-evaluate; earliest re-fire is the next tick.
  - If A=0: fire when G >= GT and not veto. Veto = (BT != 0 and B >= BT); BT=0 disables veto.
  - On fire with DUR != 0: A <= 1, D <= DUR. On fire with DUR = 0: no activation.
  - G and B of every processor are cleared to 0 on every tick (per-tick token window).
- GT=0 with no veto: an idle processor fires on every tick. An active processor stays high for exactly DUR ticks.
- uo_out[i] = A of processor i (level output, registered, no combinational path from inputs).

Optional Feature:
- Macro TTT_PULSE_OUT_EN.
- Defined: uo_out[i] is a one-cycle pulse, high only in the cycle after the TICK on which processor i activated. Internal A/D behaviour is unchanged.
- Undefined: uo_out[i] = A (level) as above.

Test Plan:
- Reset: rst_n=1 for 2 cycles with arbitrary ui_in -> uo_out=0, uio_out=0, uio_oe=0; a following TICK produces no activity (all params 0, DUR=0).
- Basic fire: proc 3 LOAD GT=5, DUR=2; TOKEN good 5; TICK -> uo_out=0x08; TICK -> 0x08; TICK -> 0x00.
- Sub-threshold and window clear: proc 0 GT=5, DUR=1; TOKEN good 4; TICK -> 0x00; TOKEN good 1; TICK -> 0x00 (count was cleared).
- Veto: proc 1 GT=2, BT=3, DUR=1; good 2, bad 3; TICK -> 0x00. Repeat with bad 2 -> 0x02. With BT=0 and bad 255 -> 0x02.
- Saturation, ena and address: TOKEN good 200 twice with GT=255 -> fires. Commands with ena=0 or address >= NUM_PROC change nothing.
- Reset mid-activity: proc 2 active with DUR=10, assert rst_n after 3 ticks -> uo_out=0 next cycle; re-fire requires reprogramming.
